// File: rtl/nios_system_hpi_pio_master.sv
// nios_system_hpi_pio_master
// Avalon-MM initiator that performs complete CY7C67200 HPI read/write
// transactions by driving the five OTG HPI PIO slaves (cs, rd, wr, addr,
// data) with single-cycle, zero-wait-state register writes/reads.
//
// Parameters:
//   HOLD_CYCLES     cycles the rd/wr strobe stays asserted (1..15)
//
// Ports:
//   clk, reset_n    clock and synchronous active-low reset
//   cmd_*           fabric command port (valid/ready handshake)
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       last read result, held until the next read completes
//   busy            inverse of cmd_ready
//   avm_*           Avalon-MM initiator towards the PIO slaves;
//                   avm_chipselect is one-hot: [0] cs [1] rd [2] wr
//                   [3] addr [4] data
//
// Optional feature (macro HPI_PIO_MASTER_INIT_EN): after reset the FSM
// first deasserts the cs, rd and wr pins before accepting commands.

module nios_system_hpi_pio_master #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [4:0]  avm_chipselect,
  output logic [1:0]  avm_address,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET_ADDR,
    S_SET_DATA,
    S_ASSERT_CS,
    S_ASSERT_STROBE,
    S_HOLD,
    S_SAMPLE,
    S_DEASSERT_STROBE,
    S_DEASSERT_CS,
    S_RESP,
    S_INIT_CS,
    S_INIT_RD,
    S_INIT_WR
  } state_t;

  localparam logic [4:0] SEL_CS   = 5'b00001;
  localparam logic [4:0] SEL_RD   = 5'b00010;
  localparam logic [4:0] SEL_WR   = 5'b00100;
  localparam logic [4:0] SEL_ADDR = 5'b01000;
  localparam logic [4:0] SEL_DATA = 5'b10000;

  // HPI pins are active-low: writing 0 asserts a pin, writing 1 releases it.
  localparam logic [31:0] PIN_ASSERT   = 32'h0000_0000;
  localparam logic [31:0] PIN_DEASSERT = 32'h0000_0001;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

`ifdef HPI_PIO_MASTER_INIT_EN
  localparam state_t RESET_STATE = S_INIT_CS;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic [4:0]  strobe_sel;

  // Only the low half of the data PIO carries HPI data.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^avm_readdata[31:16];

  // State and captured-command registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      write_q    <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 16'h0000;
      hold_cnt_q <= 4'd0;
      rdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_cnt_q <= hold_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign strobe_sel = write_q ? SEL_WR : SEL_RD;

  // Next-state logic and the single Avalon access each state performs.
  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    hold_cnt_d     = hold_cnt_q;
    rdata_d        = rdata_q;
    avm_chipselect = 5'b00000;
    avm_write_n    = 1'b1;
    avm_writedata  = 32'h0000_0000;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = S_SET_ADDR;
        end
      end
      S_SET_ADDR: begin
        avm_chipselect = SEL_ADDR;
        avm_write_n    = 1'b0;
        avm_writedata  = {30'b0, addr_q};
        state_d        = write_q ? S_SET_DATA : S_ASSERT_CS;
      end
      S_SET_DATA: begin
        avm_chipselect = SEL_DATA;
        avm_write_n    = 1'b0;
        avm_writedata  = {16'b0, wdata_q};
        state_d        = S_ASSERT_CS;
      end
      S_ASSERT_CS: begin
        avm_chipselect = SEL_CS;
        avm_write_n    = 1'b0;
        avm_writedata  = PIN_ASSERT;
        state_d        = S_ASSERT_STROBE;
      end
      S_ASSERT_STROBE: begin
        avm_chipselect = strobe_sel;
        avm_write_n    = 1'b0;
        avm_writedata  = PIN_ASSERT;
        hold_cnt_d     = HOLD_LOAD;
        state_d        = S_HOLD;
      end
      S_HOLD: begin
        // Counter was loaded with H-1, so this state lasts exactly H cycles.
        if (hold_cnt_q == 4'd0) begin
          state_d = write_q ? S_DEASSERT_STROBE : S_SAMPLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        // Data PIO readdata is combinational, valid in this same cycle.
        avm_chipselect = SEL_DATA;
        avm_write_n    = 1'b1;
        rdata_d        = avm_readdata[15:0];
        state_d        = S_DEASSERT_STROBE;
      end
      S_DEASSERT_STROBE: begin
        avm_chipselect = strobe_sel;
        avm_write_n    = 1'b0;
        avm_writedata  = PIN_DEASSERT;
        state_d        = S_DEASSERT_CS;
      end
      S_DEASSERT_CS: begin
        avm_chipselect = SEL_CS;
        avm_write_n    = 1'b0;
        avm_writedata  = PIN_DEASSERT;
        state_d        = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
`ifdef HPI_PIO_MASTER_INIT_EN
      S_INIT_CS: begin
        avm_chipselect = SEL_CS;
        avm_write_n    = 1'b0;
        avm_writedata  = PIN_DEASSERT;
        state_d        = S_INIT_RD;
      end
      S_INIT_RD: begin
        avm_chipselect = SEL_RD;
        avm_write_n    = 1'b0;
        avm_writedata  = PIN_DEASSERT;
        state_d        = S_INIT_WR;
      end
      S_INIT_WR: begin
        avm_chipselect = SEL_WR;
        avm_write_n    = 1'b0;
        avm_writedata  = PIN_DEASSERT;
        state_d        = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = ~cmd_ready;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign avm_address = 2'b00;

endmodule

// File: tb/tb_nios_system_hpi_pio_master.sv
// Testbench for nios_system_hpi_pio_master.
// Instance "a" runs with HOLD_CYCLES=4 for the transaction table, the
// input-capture check and reset during HOLD; instance "b" runs with
// HOLD_CYCLES=1 for back-to-back commands. Expected bus activity is derived
// per cycle from the transaction timing table (cycle offsets from acceptance).

module tb_nios_system_hpi_pio_master;

  localparam int H_A = 4;
  localparam int H_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        a_cmd_valid, a_cmd_write, a_cmd_ready, a_rsp_valid, a_busy, a_wn;
  logic [1:0]  a_cmd_addr, a_addr;
  logic [15:0] a_cmd_wdata, a_rsp_rdata;
  logic [4:0]  a_cs;
  logic [31:0] a_wd, a_rd, a_pio;

  logic        b_cmd_valid, b_cmd_write, b_cmd_ready, b_rsp_valid, b_busy, b_wn;
  logic [1:0]  b_cmd_addr, b_addr;
  logic [15:0] b_cmd_wdata, b_rsp_rdata;
  logic [4:0]  b_cs;
  logic [31:0] b_wd, b_rd, b_pio;

  // Data PIO model: returns the programmed value only during a data read,
  // and a junk pattern otherwise so a mistimed sample is visible.
  assign a_rd = (a_cs == 5'b10000 && a_wn) ? a_pio : 32'h5A5A_A5A5;
  assign b_rd = (b_cs == 5'b10000 && b_wn) ? b_pio : 32'h5A5A_A5A5;

  nios_system_hpi_pio_master #(.HOLD_CYCLES(H_A)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .busy(a_busy),
    .avm_chipselect(a_cs), .avm_address(a_addr), .avm_write_n(a_wn),
    .avm_writedata(a_wd), .avm_readdata(a_rd)
  );

  nios_system_hpi_pio_master #(.HOLD_CYCLES(H_B)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .avm_chipselect(b_cs), .avm_address(b_addr), .avm_write_n(b_wn),
    .avm_writedata(b_wd), .avm_readdata(b_rd)
  );

  // Observed bus snapshot of instance a: {cs, write_n, writedata, rsp_valid,
  // cmd_ready, busy, address}.
  logic [42:0] a_obs;
  assign a_obs = {a_cs, a_wn, a_wd, a_rsp_valid, a_cmd_ready, a_busy, a_addr};

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [1:0]  ad;
    logic [15:0] wdat;
    logic [31:0] pio;
    bit          glitch;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] busWord(logic [4:0] cs, logic wn,
                                          logic [31:0] wd, logic rv, logic rdy);
    return {cs, wn, wd, rv, rdy, ~rdy, 2'b00};
  endfunction

  // Expected bus in cycle cyc (1..7+h) after accepting a command.
  function automatic logic [42:0] expCycle(bit wr, logic [1:0] ad,
                                           logic [15:0] wdat, int h, int cyc);
    logic [4:0]  cs = 5'b00000;
    logic        wn = 1'b1;
    logic [31:0] wd = 32'h0;
    logic [4:0]  strobe = wr ? 5'b00100 : 5'b00010;
    if (cyc == 1) begin cs = 5'b01000; wn = 1'b0; wd = {30'b0, ad}; end
    if (wr) begin
      if (cyc == 2) begin cs = 5'b10000; wn = 1'b0; wd = {16'b0, wdat}; end
      if (cyc == 3) begin cs = 5'b00001; wn = 1'b0; end
      if (cyc == 4) begin cs = strobe;   wn = 1'b0; end
    end else begin
      if (cyc == 2)     begin cs = 5'b00001; wn = 1'b0; end
      if (cyc == 3)     begin cs = strobe;   wn = 1'b0; end
      if (cyc == 4 + h) begin cs = 5'b10000; wn = 1'b1; end
    end
    if (cyc == 5 + h) begin cs = strobe;   wn = 1'b0; wd = 32'h1; end
    if (cyc == 6 + h) begin cs = 5'b00001; wn = 1'b0; wd = 32'h1; end
    return busWord(cs, wn, wd, cyc == 7 + h, 1'b0);
  endfunction

  // Expected bus in cycle c after the last reset-asserted edge.
  function automatic logic [42:0] expPostReset(int c);
    logic [42:0] w = busWord(5'b00000, 1'b1, 32'h0, 1'b0, 1'b1);
`ifdef HPI_PIO_MASTER_INIT_EN
    if (c >= 1 && c <= 3) w = busWord(5'(1 << (c - 1)), 1'b0, 32'h1, 1'b0, 1'b0);
`endif
    return w;
  endfunction

  // Called at the negedge of the first cycle after a reset edge; releases
  // reset and watches the following cycles.
  task automatic checkPostReset(input string tag);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      checkOutput($sformatf("%s_c%0d", tag, c), 64'(a_obs), 64'(expPostReset(c)));
      if (c == 1) reset_n = 1'b1;
    end
    checkOutput({tag, "_rdata"}, 64'(a_rsp_rdata), 64'h0);
  endtask

  task automatic waitReadyA(output bit ok);
    int k = 0;
    @(negedge clk);
    while (!a_cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = a_cmd_ready;
    if (!ok) checkOutput("ready_timeout", 64'(a_cmd_ready), 64'h1);
  endtask

  // One full transaction on instance a, checked every cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    bit ok;
    waitReadyA(ok);
    if (!ok) return;
    a_cmd_valid = 1'b1;
    a_cmd_write = v.wr;
    a_cmd_addr  = v.ad;
    a_cmd_wdata = v.wdat;
    a_pio       = v.pio;
    for (int cyc = 1; cyc <= 7 + H_A; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        a_cmd_valid = 1'b0;
        a_cmd_write = ~v.wr;
        a_cmd_addr  = 2'($urandom);
        a_cmd_wdata = v.glitch ? 16'hFFFF : 16'($urandom);
      end
      checkOutput($sformatf("v%0d_cyc%0d", idx, cyc), 64'(a_obs),
                  64'(expCycle(v.wr, v.ad, v.wdat, H_A, cyc)));
    end
    @(negedge clk);
    checkOutput($sformatf("v%0d_ready", idx), 64'({a_cmd_ready, a_rsp_valid}), 64'h2);
    checkOutput($sformatf("v%0d_rdata", idx), 64'(a_rsp_rdata), 64'(v.exp_rdata));
  endtask

  task automatic resetDuringHold();
    bit ok;
    waitReadyA(ok);
    if (!ok) return;
    a_cmd_valid = 1'b1;
    a_cmd_write = 1'b1;
    a_cmd_addr  = 2'd2;
    a_cmd_wdata = 16'h1234;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_cmd_valid = 1'b0;
      checkOutput($sformatf("rh_cyc%0d", cyc), 64'(a_obs),
                  64'(expCycle(1'b1, 2'd2, 16'h1234, H_A, cyc)));
    end
    reset_n = 1'b0;
    @(negedge clk);
    checkPostReset("rst_hold");
  endtask

  // H=1 instance: write then read with cmd_valid held high throughout.
  task automatic backToBack();
    int first = -1;
    int second = -1;
    int cyc = 0;
    @(negedge clk);
    b_cmd_valid = 1'b1;
    b_cmd_write = 1'b1;
    b_cmd_addr  = 2'd2;
    b_cmd_wdata = 16'h0F0F;
    b_pio       = 32'h7777_C3C3;
    while (cyc < 40) begin
      if (first >= 0 && cyc > first && cyc <= first + 9) begin
        checkOutput($sformatf("b2b_ready_c%0d", cyc - first), 64'(b_cmd_ready),
                    64'(cyc == first + 9));
        checkOutput($sformatf("b2b_rsp_c%0d", cyc - first), 64'(b_rsp_valid),
                    64'(cyc == first + 8));
      end
      if (second >= 0 && cyc == second + 9) begin
        checkOutput("b2b_rdata", 64'(b_rsp_rdata), 64'h0000_C3C3);
        break;
      end
      if (b_cmd_valid && b_cmd_ready) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      @(negedge clk);
      cyc++;
      if (first >= 0 && cyc == first + 1) begin
        b_cmd_write = 1'b0;
        b_cmd_addr  = 2'd0;
        b_cmd_wdata = 16'hAAAA;
      end
      if (second >= 0 && cyc == second + 1) b_cmd_valid = 1'b0;
    end
    checkOutput("b2b_spacing", 64'(second - first), 64'd9);
  endtask

  initial begin
    logic [15:0] model_rd;
    reset_n     = 1'b0;
    a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_addr = 2'd0; a_cmd_wdata = 16'h0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = 2'd0; b_cmd_wdata = 16'h0;
    a_pio = 32'h0; b_pio = 32'h0;

    vecs[0] = '{1'b1, 2'd2, 16'h1234, 32'h0000_0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 2'd0, 16'h0000, 32'hDEAD_BEEF, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 2'd1, 16'h00A5, 32'h0000_0000, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 2'd3, 16'h0000, 32'h0000_8001, 1'b0, 16'h8001};
    vecs[4] = '{1'b1, 2'd0, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, 16'h8001};
    vecs[5] = '{1'b0, 2'd1, 16'h0000, 32'h1234_0000, 1'b0, 16'h0000};
    model_rd = 16'h0000;
    for (int i = 6; i < 16; i++) begin
      vecs[i].wr     = 1'($urandom);
      vecs[i].ad     = 2'($urandom);
      vecs[i].wdat   = 16'($urandom);
      vecs[i].pio    = $urandom;
      vecs[i].glitch = 1'b0;
      if (!vecs[i].wr) model_rd = vecs[i].pio[15:0];
      vecs[i].exp_rdata = model_rd;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkPostReset("reset");

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    resetDuringHold();
    backToBack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
